// File: rtl/jtag_if.sv
// AHB-Lite bus bundle between the JTAG debug bridge (master) and the system bus (slave).
interface jtag_if #(
  parameter int REGISTER_SIZE = 32
);
  logic                     HREADY;
  logic [REGISTER_SIZE-1:0] HRDATA;
  logic                     HRESP;
  logic                     HWRITE;
  logic [1:0]               HTRANS;
  logic [REGISTER_SIZE-1:0] HADDR;
  logic [REGISTER_SIZE-1:0] HWDATA;

  modport master (
    input  HREADY, HRDATA, HRESP,
    output HWRITE, HTRANS, HADDR, HWDATA
  );

  modport slave (
    output HREADY, HRDATA, HRESP,
    input  HWRITE, HTRANS, HADDR, HWDATA
  );
endinterface

// File: rtl/jtag.sv
// IEEE 1149.1 TAP controller bridging IR-selected data registers onto single AHB-Lite transfers.
module jtag #(
  parameter int                       REGISTER_SIZE = 32,
  parameter int                       IR_SIZE       = 4,
  parameter int                       STATE_SIZE    = 4,
  parameter logic [REGISTER_SIZE-1:0] IDCODE_VALUE  = 32'h1234_5677
) (
  input  logic   TCK,
  input  logic   TRST_N,
  input  logic   TMS,
  input  logic   TDI,
  output logic   TDO,
  jtag_if.master ahb
);

  typedef enum logic [STATE_SIZE-1:0] {
    TLR      = STATE_SIZE'(4'hF),
    RTI      = STATE_SIZE'(4'hC),
    SEL_DR   = STATE_SIZE'(4'h7),
    CAP_DR   = STATE_SIZE'(4'h6),
    SH_DR    = STATE_SIZE'(4'h2),
    EX1_DR   = STATE_SIZE'(4'h1),
    PAUSE_DR = STATE_SIZE'(4'h3),
    EX2_DR   = STATE_SIZE'(4'h0),
    UPD_DR   = STATE_SIZE'(4'h5),
    SEL_IR   = STATE_SIZE'(4'h4),
    CAP_IR   = STATE_SIZE'(4'hE),
    SH_IR    = STATE_SIZE'(4'hA),
    EX1_IR   = STATE_SIZE'(4'h9),
    PAUSE_IR = STATE_SIZE'(4'hB),
    EX2_IR   = STATE_SIZE'(4'h8),
    UPD_IR   = STATE_SIZE'(4'hD)
  } tap_state_t;

  typedef enum logic [1:0] {
    AHB_IDLE,
    AHB_ADDR,
    AHB_DATA
  } ahb_state_t;

  localparam logic [IR_SIZE-1:0] IR_IDCODE = IR_SIZE'(4'b1000);
  localparam logic [IR_SIZE-1:0] IR_ADDR   = IR_SIZE'(4'b0100);
  localparam logic [IR_SIZE-1:0] IR_WDATA  = IR_SIZE'(4'b1100);
  localparam logic [IR_SIZE-1:0] IR_RDATA  = IR_SIZE'(4'b0010);

  tap_state_t               tap_state_reg, tap_state_next;
  ahb_state_t               ahb_state_reg, ahb_state_next;
  logic [IR_SIZE-1:0]       ir_reg, ir_shift_reg;
  logic [REGISTER_SIZE-1:0] dr_shift_reg;
  logic                     bypass_reg;
  logic                     write_reg, write_next;
  logic [REGISTER_SIZE-1:0] haddr_reg, haddr_next;
  logic [REGISTER_SIZE-1:0] hwdata_reg, hwdata_next;
  logic [REGISTER_SIZE-1:0] rdata_reg, rdata_next;
  logic                     tdo_reg;
  logic                     sel_idcode, sel_addr, sel_wdata, sel_rdata, sel_bypass;

  assign sel_idcode = (ir_reg == IR_IDCODE);
  assign sel_addr   = (ir_reg == IR_ADDR);
  assign sel_wdata  = (ir_reg == IR_WDATA);
  assign sel_rdata  = (ir_reg == IR_RDATA);
  assign sel_bypass = !(sel_idcode || sel_addr || sel_wdata || sel_rdata);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) tap_state_reg <= TLR;
    else         tap_state_reg <= tap_state_next;
  end

  always_comb begin
    tap_state_next = tap_state_reg;
    case (tap_state_reg)
      TLR:      tap_state_next = TMS ? TLR      : RTI;
      RTI:      tap_state_next = TMS ? SEL_DR   : RTI;
      SEL_DR:   tap_state_next = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_state_next = TMS ? EX1_DR   : SH_DR;
      SH_DR:    tap_state_next = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   tap_state_next = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_state_next = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   tap_state_next = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   tap_state_next = TMS ? SEL_DR   : RTI;
      SEL_IR:   tap_state_next = TMS ? TLR      : CAP_IR;
      CAP_IR:   tap_state_next = TMS ? EX1_IR   : SH_IR;
      SH_IR:    tap_state_next = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   tap_state_next = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_state_next = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   tap_state_next = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   tap_state_next = TMS ? SEL_DR   : RTI;
      default:  tap_state_next = TLR;
    endcase
  end

  // Shift registers act on the state being left, so the exit edge of Shift-xR still shifts.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_reg       <= IR_IDCODE;
      ir_shift_reg <= '0;
      dr_shift_reg <= '0;
      bypass_reg   <= 1'b0;
    end else begin
      case (tap_state_reg)
        CAP_IR: ir_shift_reg <= IR_SIZE'(1);
        SH_IR:  ir_shift_reg <= {TDI, ir_shift_reg[IR_SIZE-1:1]};
        UPD_IR: ir_reg <= ir_shift_reg;
        CAP_DR: begin
          bypass_reg <= 1'b0;
          if (sel_idcode)     dr_shift_reg <= IDCODE_VALUE;
          else if (sel_addr)  dr_shift_reg <= haddr_reg;
          else if (sel_wdata) dr_shift_reg <= hwdata_reg;
          else if (sel_rdata) dr_shift_reg <= rdata_reg;
          else                dr_shift_reg <= '0;
        end
        SH_DR: begin
          if (sel_bypass) bypass_reg <= TDI;
          else            dr_shift_reg <= {TDI, dr_shift_reg[REGISTER_SIZE-1:1]};
        end
        default: ;
      endcase
      if (tap_state_next == TLR) ir_reg <= IR_IDCODE;
    end
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      tdo_reg <= 1'b0;
    end else begin
      case (tap_state_reg)
        SH_IR:   tdo_reg <= ir_shift_reg[0];
        SH_DR:   tdo_reg <= sel_bypass ? bypass_reg : dr_shift_reg[0];
        default: tdo_reg <= 1'b0;
      endcase
    end
  end

  assign TDO = tdo_reg;

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ahb_state_reg <= AHB_IDLE;
      write_reg     <= 1'b0;
      haddr_reg     <= '0;
      hwdata_reg    <= '0;
      rdata_reg     <= '0;
    end else begin
      ahb_state_reg <= ahb_state_next;
      write_reg     <= write_next;
      haddr_reg     <= haddr_next;
      hwdata_reg    <= hwdata_next;
      rdata_reg     <= rdata_next;
    end
  end

  // Only one transfer may be outstanding; an Update-DR arriving while busy is dropped whole.
  always_comb begin
    ahb_state_next = ahb_state_reg;
    write_next     = write_reg;
    haddr_next     = haddr_reg;
    hwdata_next    = hwdata_reg;
    rdata_next     = rdata_reg;
    case (ahb_state_reg)
      AHB_ADDR: ahb_state_next = AHB_DATA;
      AHB_DATA: begin
        if (ahb.HREADY || ahb.HRESP) begin
          ahb_state_next = AHB_IDLE;
          if (!write_reg) rdata_next = ahb.HRESP ? '0 : ahb.HRDATA;
        end
      end
      default: ;
    endcase
    if (tap_state_reg == UPD_DR) begin
      if (sel_addr) haddr_next = dr_shift_reg;
      if (ahb_state_reg == AHB_IDLE && sel_wdata) begin
        hwdata_next    = dr_shift_reg;
        write_next     = 1'b1;
        ahb_state_next = AHB_ADDR;
      end
      if (ahb_state_reg == AHB_IDLE && sel_rdata) begin
        write_next     = 1'b0;
        ahb_state_next = AHB_ADDR;
      end
    end
    if (tap_state_next == TLR) ahb_state_next = AHB_IDLE;
  end

  assign ahb.HTRANS = (ahb_state_reg == AHB_ADDR) ? 2'b10 : 2'b00;
  assign ahb.HWRITE = (ahb_state_reg == AHB_ADDR) && write_reg;
  assign ahb.HADDR  = haddr_reg;
  assign ahb.HWDATA = hwdata_reg;

endmodule

// File: tb/tb_jtag.sv
// Randomized bench for the JTAG-to-AHB bridge, checked every cycle against a table-driven TAP/bus model.
module tb_jtag;
  localparam logic [31:0] IDC    = 32'h1234_5677;
  localparam logic [3:0]  C_ID   = 4'b1000;
  localparam logic [3:0]  C_ADDR = 4'b0100;
  localparam logic [3:0]  C_WD   = 4'b1100;
  localparam logic [3:0]  C_RD   = 4'b0010;
  localparam int S_TLR = 0, S_RTI = 1, S_SDS = 2, S_CDR = 3, S_SDR = 4, S_E1D = 5, S_PDR = 6, S_E2D = 7;
  localparam int S_UDR = 8, S_SIS = 9, S_CIR = 10, S_SIR = 11, S_E1I = 12, S_PIR = 13, S_E2I = 14, S_UIR = 15;

  logic TCK, TRST_N, TMS, TDI, TDO;
  jtag_if #(.REGISTER_SIZE(32)) bus ();

  jtag #(.REGISTER_SIZE(32)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .TMS(TMS), .TDI(TDI), .TDO(TDO), .ahb(bus.master)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

  int n_err = 0;
  int n_chk = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  bit chk_on = 0;
  int bus_mode = 1;
  logic [31:0] fixed_rdata = 32'h0000_F00F;

  // Reference model: TAP walk by transition table, registers as bit queues, bus as a phase number.
  int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int m_state, m_phase;
  bit m_write;
  logic [3:0]  m_ir;
  logic [31:0] m_haddr, m_hwdata, m_rdata;
  bit ir_q[$];
  bit dr_q[$];
  logic e_tdo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] qval(input bit q[$]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic bit is_byp(input logic [3:0] c);
    return !(c == C_ID || c == C_ADDR || c == C_WD || c == C_RD);
  endfunction

  task automatic model_reset();
    m_state = S_TLR; m_phase = 0; m_write = 0; m_ir = C_ID;
    m_haddr = '0; m_hwdata = '0; m_rdata = '0; e_tdo = 1'b0;
    ir_q.delete(); dr_q.delete();
  endtask

  task automatic model_edge();
    int ns, np, len;
    logic [31:0] cap, tmp;
    case (m_state)
      S_CIR: begin
        ir_q.delete(); ir_q.push_back(1'b1);
        repeat (3) ir_q.push_back(1'b0);
      end
      S_SIR: begin void'(ir_q.pop_front()); ir_q.push_back(TDI); end
      S_UIR: begin tmp = qval(ir_q); m_ir = tmp[3:0]; end
      S_CDR: begin
        len = is_byp(m_ir) ? 1 : 32;
        if (m_ir == C_ID)        cap = IDC;
        else if (m_ir == C_ADDR) cap = m_haddr;
        else if (m_ir == C_WD)   cap = m_hwdata;
        else if (m_ir == C_RD)   cap = m_rdata;
        else                     cap = '0;
        dr_q.delete();
        for (int i = 0; i < len; i++) dr_q.push_back(cap[i]);
      end
      S_SDR: begin void'(dr_q.pop_front()); dr_q.push_back(TDI); end
      default: ;
    endcase
    np = m_phase;
    if (m_phase == 1) np = 2;
    else if (m_phase == 2 && (bus.HREADY || bus.HRESP)) begin
      np = 0;
      if (!m_write) m_rdata = bus.HRESP ? 32'h0 : bus.HRDATA;
    end
    if (m_state == S_UDR) begin
      tmp = qval(dr_q);
      if (m_ir == C_ADDR) m_haddr = tmp;
      else if (m_ir == C_WD && m_phase == 0) begin m_hwdata = tmp; m_write = 1; np = 1; end
      else if (m_ir == C_RD && m_phase == 0) begin m_write = 0; np = 1; end
    end
    m_phase = np;
    ns = TMS ? nxt1[m_state] : nxt0[m_state];
    if (ns == S_TLR) begin m_ir = C_ID; m_phase = 0; end
    m_state = ns;
    e_tdo = (ns == S_SIR) ? ir_q[0] : (ns == S_SDR) ? dr_q[0] : 1'b0;
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    case (bus_mode)
      0: begin
        bus.HREADY = ($urandom_range(0, 3) != 0);
        bus.HRESP  = ($urandom_range(0, 15) == 0);
        bus.HRDATA = $urandom;
      end
      1: begin bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = fixed_rdata; end
      default: begin bus.HREADY = 1'b0; bus.HRESP = 1'b0; bus.HRDATA = $urandom; end
    endcase
    @(posedge TCK);
    model_edge();
    @(negedge TCK);
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  initial begin
    forever begin
      @(negedge TCK);
      #1;
      if (bus.HTRANS == 2'b10 && bus.HWRITE === 1'b1) wr_cnt++;
      if (bus.HTRANS == 2'b10 && bus.HWRITE === 1'b0) rd_cnt++;
      if (chk_on) begin
        check("tdo",    {31'b0, TDO},        {31'b0, e_tdo});
        check("htrans", {30'b0, bus.HTRANS}, (m_phase == 1) ? 32'd2 : 32'd0);
        check("hwrite", {31'b0, bus.HWRITE}, {31'b0, (m_phase == 1) && m_write});
        check("haddr",  bus.HADDR,           m_haddr);
        check("hwdata", bus.HWDATA,          m_hwdata);
      end
    end
  end

  task automatic load_ir(input logic [3:0] code);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, code[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    dout = '0;
    step(1, 0); step(0, 0); step(0, 0);
    #1 dout[0] = TDO;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      #1 if (i < n - 1) dout[i+1] = TDO;
    end
    step(1, 0); step(0, 0);
    $display("scan ir=%b n=%0d in=%h out=%h", m_ir, n, din, dout);
  endtask

  task automatic reset_tap();
    repeat (5) step(1, 0);
    step(0, 0);
  endtask

  task automatic trst_pulse();
    chk_on = 0;
    #2 TRST_N = 1'b0;
    #2;
    check("rst_htrans", {30'b0, bus.HTRANS}, 32'd0);
    check("rst_hwrite", {31'b0, bus.HWRITE}, 32'd0);
    check("rst_haddr",  bus.HADDR,  32'd0);
    check("rst_hwdata", bus.HWDATA, 32'd0);
    check("rst_tdo",    {31'b0, TDO}, 32'd0);
    @(posedge TCK);
    @(negedge TCK);
    #2 TRST_N = 1'b1;
    model_reset();
    chk_on = 1;
  endtask

  initial begin
    logic [31:0] d, a, pat;
    int c0;
    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    model_reset();
    repeat (2) @(posedge TCK);
    @(negedge TCK);
    trst_pulse();

    step(0, 0);
    scan_dr($urandom, 32, d);
    check("idcode_after_trst", d, 32'h1234_5677);

    c0 = wr_cnt + rd_cnt;
    scan_dr(32'h89AB_CDEF, 32, d);
    scan_dr(32'h0, 32, d);
    check("idcode_readonly", d, 32'h1234_5677);
    check("idcode_no_ahb", wr_cnt + rd_cnt - c0, 32'd0);

    load_ir(C_ADDR);
    c0 = wr_cnt + rd_cnt;
    scan_dr(32'h0000_1000, 32, d);
    check("haddr_update", bus.HADDR, 32'h0000_1000);
    check("addr_no_ahb", wr_cnt + rd_cnt - c0, 32'd0);

    load_ir(C_WD);
    c0 = wr_cnt;
    scan_dr(32'hFFFF_FFFF, 32, d);
    repeat (3) step(0, 0);
    check("write_one_nonseq", wr_cnt - c0, 32'd1);
    check("hwdata_update", bus.HWDATA, 32'hFFFF_FFFF);

    bus_mode = 1;
    load_ir(C_RD);
    c0 = rd_cnt;
    scan_dr(32'h0, 32, d);
    repeat (3) step(0, 0);
    check("read_one_nonseq", rd_cnt - c0, 32'd1);
    scan_dr(32'h0, 32, d);
    check("rdata_capture", d, 32'h0000_F00F);

    // Second write while the first is stalled must be dropped.
    load_ir(C_WD);
    bus_mode = 2;
    a = $urandom;
    scan_dr(a, 32, d);
    scan_dr(~a, 32, d);
    check("busy_update_ignored", bus.HWDATA, a);
    bus_mode = 1;
    repeat (3) step(0, 0);

    bus_mode = 2;
    a = $urandom;
    scan_dr(a, 32, d);
    reset_tap();
    check("tlr_keeps_hwdata", bus.HWDATA, a);
    bus_mode = 1;

    load_ir(C_ADDR);
    step(1, 0); step(0, 0); step(0, 0);
    step(0, 1); step(0, 0); step(0, 1);
    repeat (5) step(1, 0);
    step(0, 0);
    scan_dr($urandom, 32, d);
    check("tlr_from_shift_idcode", d, 32'h1234_5677);
    load_ir(4'b0110);
    pat = $urandom;
    scan_dr(pat, 16, d);
    check("bypass_delay", {17'b0, d[15:1]}, {17'b0, pat[14:0]});
    check("bypass_first_bit", {31'b0, d[0]}, 32'd0);

    load_ir(C_WD);
    bus_mode = 2;
    scan_dr($urandom, 32, d);
    step(0, 0);
    trst_pulse();
    bus_mode = 1;
    repeat (3) step(0, 0);

    bus_mode = 0;
    step(0, 0);
    for (int it = 0; it < 40; it++) begin
      int op;
      logic [3:0] c;
      op = $urandom_range(0, 5);
      c = 4'($urandom);
      case (op)
        0: load_ir(C_ADDR);
        1: load_ir(C_WD);
        2: load_ir(C_RD);
        3: load_ir(C_ID);
        4: load_ir(c);
        default: reset_tap();
      endcase
      scan_dr($urandom, (op == 4) ? 8 : 32, d);
      repeat ($urandom_range(0, 4)) step(0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/jtag.md
JTAG -- requirements
Module: jtag

Interface
REQ-001 Parameter REGISTER_SIZE, default 32: width of the data registers, HADDR, HWDATA and HRDATA.
REQ-002 Parameter IR_SIZE, default 4: instruction register width.
REQ-003 Parameter STATE_SIZE, default 4: TAP state encoding width.
REQ-004 Parameter IDCODE_VALUE, default 32'h1234_5677: device ID with LSB = 1.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
REQ-006 TCK  in  1: sole clock.
REQ-007 TRST_N  in  1: reset.
REQ-008 TMS  in  1: TAP mode select, sampled on rising TCK.
REQ-009 TDI  in  1: serial data in, sampled on rising TCK.
REQ-010 TDO  out  1: serial data out.
REQ-011 HREADY  in  1: AHB-Lite transfer ready.
REQ-012 HRDATA  in  REGISTER_SIZE: AHB-Lite read data.
REQ-013 HRESP  in  1: AHB-Lite error response.
REQ-014 HWRITE  out  1: 1 = write transfer.
REQ-015 HTRANS  out  2: IDLE = 2'b00, NONSEQ = 2'b10.
REQ-016 HADDR  out  REGISTER_SIZE: transfer address.
REQ-017 HWDATA  out  REGISTER_SIZE: write data.

Function
REQ-018 The TAP controller SHALL implement all 16 IEEE 1149.1 states with standard TMS transitions on rising TCK.
REQ-019 Five consecutive TMS = 1 cycles SHALL reach Test-Logic-Reset from any state.
REQ-020 IR codes SHALL be decoded as follows:
- BYPASS = 4'b0000
- IDCODE = 4'b1000
- ADDR = 4'b0100
- WDATA = 4'b1100
- RDATA = 4'b0010
- any other code = BYPASS
REQ-021 IR and data shift registers SHALL shift right, TDI entering the MSB and the LSB driving TDO, so values shift LSB first.
REQ-022 Capture-IR SHALL load 4'b0001 into the IR shift register.
REQ-023 Update-IR SHALL latch the IR shift register into the active IR.
REQ-024 Capture-DR SHALL load the selected register:
- IDCODE: IDCODE_VALUE
- ADDR: current HADDR
- WDATA: current HWDATA
- RDATA: read-data register
- BYPASS: 1-bit 0
REQ-025 The IDCODE register SHALL be read-only; Update-DR under IDCODE changes nothing.
REQ-026 Update-DR under ADDR SHALL latch the shifted value into HADDR.
REQ-027 Update-DR under WDATA SHALL latch the shifted value into HWDATA and start a write: next TCK HTRANS = NONSEQ and HWRITE = 1 for exactly one cycle, then HTRANS = IDLE.
REQ-028 Update-DR under RDATA SHALL start a read: next TCK HTRANS = NONSEQ and HWRITE = 0 for exactly one cycle, then IDLE.
REQ-029 Data phase SHALL follow the address phase and be extended while HREADY = 0.
REQ-030 On the first data-phase cycle with HREADY = 1, a read SHALL latch HRDATA into the read-data register.
REQ-031 HRESP = 1 in the data phase SHALL end the transfer; on a read, the read-data register is set to 0.
REQ-032 An Update-DR that starts a transfer while a previous one is still in progress SHALL be ignored.
REQ-033 HWDATA SHALL stay stable through the data phase.
REQ-034 TDO SHALL update on falling TCK; it carries the shift-register LSB in Shift-IR/Shift-DR and is 0 otherwise.
REQ-035 Shift-DR SHALL shift one bit per cycle including the exit cycle (TMS = 1), so a 32-bit register needs 32 Shift-DR cycles.

Reset
REQ-036 TRST_N low SHALL asynchronously force:
- TAP state = Test-Logic-Reset
- active IR = IDCODE
- HTRANS = IDLE, HWRITE = 0
- HADDR = 0, HWDATA = 0
- read-data register = 0, TDO = 0
- any AHB transfer aborted
REQ-037 Entering Test-Logic-Reset via TMS SHALL set IR = IDCODE and HTRANS = IDLE, leaving HADDR/HWDATA unchanged.

Verification
REQ-038 TRST_N pulse, then IR = IDCODE, shift DR 32 bits -> TDO emits 32'h1234_5677 LSB first.
REQ-039 IR = IDCODE, shift in 32'h89ABCDEF, Update-DR, shift again -> TDO still emits 32'h1234_5677 with no AHB activity.
REQ-040 IR = ADDR, shift in 32'h0000_1000, Update-DR -> HADDR = 32'h0000_1000 and HTRANS stays IDLE.
REQ-041 IR = WDATA, shift in 32'hFFFF_FFFF, Update-DR -> one cycle HTRANS = 2'b10 with HWRITE = 1, then IDLE, and HWDATA = 32'hFFFF_FFFF.
REQ-042 IR = RDATA with HRDATA = 32'h0000_F00F and HREADY = 1, Update-DR then a second capture/shift -> one NONSEQ read (HWRITE = 0), and TDO emits 32'h0000_F00F.
REQ-043 TMS held 1 for 5 cycles from Shift-DR -> Test-Logic-Reset and IR = IDCODE; IR = 4'b0110 -> 1-cycle bypass delay TDI to TDO.
